// File: rtl/dadda_mult_pipe_if.sv
// Operand/result handshake bundle for dadda_mult_pipe.
// Defining DADDA_MULT_SIGNED_EN adds the per-operation in_signed select.
interface dadda_mult_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [TAG_W-1:0]   in_tag;
`ifdef DADDA_MULT_SIGNED_EN
  logic               in_signed;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

`ifdef DADDA_MULT_SIGNED_EN
  modport master (output in_valid, in_a, in_b, in_tag, in_signed, out_ready,
                  input  in_ready, out_valid, out_p, out_tag, busy);
  modport slave  (input  in_valid, in_a, in_b, in_tag, in_signed, out_ready,
                  output in_ready, out_valid, out_p, out_tag, busy);
`else
  modport master (output in_valid, in_a, in_b, in_tag, out_ready,
                  input  in_ready, out_valid, out_p, out_tag, busy);
  modport slave  (input  in_valid, in_a, in_b, in_tag, out_ready,
                  output in_ready, out_valid, out_p, out_tag, busy);
`endif
endinterface

// File: rtl/dadda_mult_pipe.sv
// Pipelined Dadda-tree multiplier with tag, valid/ready handshake and global stall.
// Optional macro DADDA_MULT_SIGNED_EN enables per-operation Baugh-Wooley signed mode.
module dadda_mult_pipe #(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dadda_mult_pipe_if.slave bus
);
  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = WIDTH;

  // Bit matrix: row r, column c holds the r-th bit of weight 2^c.
  typedef logic [ROWS-1:0][PW-1:0] mat_t;

  // Dadda height sequence 2, 3, 4, 6, 9, 13, ...
  function automatic int dadda_target(input int k);
    int d;
    d = 2;
    for (int i = 0; i < 16; i++)
      if (i < k) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic int count_layers();
    int n;
    n = 0;
    for (int k = 0; k < 16; k++)
      if (dadda_target(k) < ROWS) n++;
    return n;
  endfunction

  localparam int LAYERS = count_layers();

  function automatic int init_height(input int c);
    int h;
    h = 0;
    for (int i = 0; i < WIDTH; i++)
      if (c - i >= 0 && c - i < WIDTH) h++;
`ifdef DADDA_MULT_SIGNED_EN
    if (c == WIDTH || c == PW - 1) h++;
`endif
    return h;
  endfunction

  // Baugh-Wooley: cross terms with exactly one sign bit are inverted and
  // ones are added at weights WIDTH and 2*WIDTH-1 when sgn is set.
  function automatic mat_t gen_pp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sgn);
    mat_t m;
    int   cnt [PW];
    logic pp_bit;
    m = '0;
    for (int c = 0; c < PW; c++) cnt[c] = 0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_bit = a[i] & b[j];
        if ((i == WIDTH - 1) != (j == WIDTH - 1)) pp_bit = pp_bit ^ sgn;
        m[cnt[i+j]][i+j] = pp_bit;
        cnt[i+j]++;
      end
    end
`ifdef DADDA_MULT_SIGNED_EN
    m[cnt[WIDTH]][WIDTH] = sgn;
    m[cnt[PW-1]][PW-1]   = sgn;
`endif
    return m;
  endfunction

  // Column heights depend only on parameters, so every layer is walked for
  // bookkeeping while only layers lo..hi-1 actually transform the data.
  function automatic mat_t reduce(input mat_t m_in, input int lo, input int hi);
    mat_t            m;
    mat_t            nm;
    int              h  [PW];
    int              nh [PW];
    logic [ROWS-1:0] cy_prev;
    logic [ROWS-1:0] cy_cur;
    int              n_prev, n_cur, excess, n_fa, n_ha, src, dst, d;
    logic [1:0]      s3;
    m = m_in;
    for (int c = 0; c < PW; c++) h[c] = init_height(c);
    for (int k = 0; k < LAYERS; k++) begin
      d       = dadda_target(LAYERS - 1 - k);
      nm      = '0;
      n_prev  = 0;
      cy_prev = '0;
      for (int c = 0; c < PW; c++) begin
        excess = h[c] + n_prev - d;
        n_fa   = (excess > 0) ? excess / 2 : 0;
        n_ha   = (excess > 0) ? excess % 2 : 0;
        dst    = 0;
        src    = 0;
        n_cur  = 0;
        cy_cur = '0;
        for (int r = 0; r < ROWS; r++)
          if (r < n_prev) begin
            nm[dst][c] = cy_prev[r];
            dst++;
          end
        for (int r = 0; r < ROWS; r++)
          if (r < n_fa) begin
            s3 = {1'b0, m[src][c]} + {1'b0, m[src+1][c]} + {1'b0, m[src+2][c]};
            nm[dst][c]    = s3[0];
            cy_cur[n_cur] = s3[1];
            dst++;
            n_cur++;
            src += 3;
          end
        if (n_ha > 0) begin
          s3 = {1'b0, m[src][c]} + {1'b0, m[src+1][c]};
          nm[dst][c]    = s3[0];
          cy_cur[n_cur] = s3[1];
          dst++;
          n_cur++;
          src += 2;
        end
        for (int r = 0; r < ROWS; r++)
          if (r >= src && r < h[c]) begin
            nm[dst][c] = m[r][c];
            dst++;
          end
        nh[c]   = dst;
        cy_prev = cy_cur;
        n_prev  = n_cur;
      end
      for (int c = 0; c < PW; c++) h[c] = nh[c];
      if (k >= lo && k < hi) m = nm;
    end
    return m;
  endfunction

  logic                   en;
  logic                   sgn;
  logic [PIPE_STAGES-1:0] vld_r;
  logic [TAG_W-1:0]       tag_r [PIPE_STAGES];
  logic [PW-1:0]          p_r;
  mat_t                   stage_in  [PIPE_STAGES];
  mat_t                   stage_out [PIPE_STAGES];

`ifdef DADDA_MULT_SIGNED_EN
  assign sgn = bus.in_signed;
`else
  assign sgn = 1'b0;
`endif

  // Global stall: only the output stage can hold the pipe back.
  assign en            = !vld_r[PIPE_STAGES-1] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_r[PIPE_STAGES-1];
  assign bus.busy      = |vld_r;
  assign bus.out_p     = p_r;
  assign bus.out_tag   = tag_r[PIPE_STAGES-1];

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam int LO = (s * LAYERS) / PIPE_STAGES;
    localparam int HI = ((s + 1) * LAYERS) / PIPE_STAGES;
    if (s == 0) begin : g_in
      assign stage_in[s] = gen_pp(bus.in_a, bus.in_b, sgn);
    end else begin : g_reg
      mat_t mat_r;
      always_ff @(posedge clk) begin
        if (en) mat_r <= stage_out[s-1];
      end
      assign stage_in[s] = mat_r;
    end
    assign stage_out[s] = reduce(stage_in[s], LO, HI);
  end

  // Control and tags reset; the last stage adds the two surviving rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= '0;
      p_r   <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) tag_r[i] <= '0;
    end else if (en) begin
      vld_r[0] <= bus.in_valid;
      tag_r[0] <= bus.in_tag;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        vld_r[i] <= vld_r[i-1];
        tag_r[i] <= tag_r[i-1];
      end
      p_r <= stage_out[PIPE_STAGES-1][0] + stage_out[PIPE_STAGES-1][1];
    end
  end
endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Self-checking bench for dadda_mult_pipe: directed cases plus randomized traffic
// scored against an arithmetic reference queue (signed cases under DADDA_MULT_SIGNED_EN).
module tb_dadda_mult_pipe;
  localparam int W  = 16;
  localparam int S  = 3;
  localparam int TG = 4;
  localparam int PW = 2 * W;

  typedef struct {
    logic [PW-1:0] p;
    logic [TG-1:0] tag;
    int            acc;
    bit            no_stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   head_shown = 1'b0;
  bit   src_done;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dadda_mult_pipe_if #(.WIDTH(W), .TAG_W(TG)) bus ();

  dadda_mult_pipe #(.WIDTH(W), .PIPE_STAGES(S), .TAG_W(TG)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    return PW'(sa * sb);
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [TG-1:0] t, input bit sgn);
    int waits = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = t;
`ifdef DADDA_MULT_SIGNED_EN
    bus.in_signed = sgn;
`else
    if (sgn) $display("[TB] note: signed request issued to unsigned build");
`endif
    @(negedge clk);
    while (!bus.in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("drain", q.size(), 0);
  endtask

  // Reference scoreboard, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    bit   s;
    if (!rst_n) begin
      q.delete();
      head_shown = 1'b0;
    end else begin
      checkOutput("busy", bus.busy, q.size() != 0);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checkOutput("spurious_valid", bus.out_valid, 1'b0);
        end else begin
          if (!head_shown) begin
            head_shown = 1'b1;
            if (q[0].no_stall) checkOutput("latency", cyc - q[0].acc, S);
          end
          checkOutput("out_p", bus.out_p, q[0].p);
          checkOutput("out_tag", bus.out_tag, q[0].tag);
          checkOutput("in_ready_vs_sink", bus.in_ready, bus.out_ready);
          if (bus.out_ready) begin
            void'(q.pop_front());
            head_shown = 1'b0;
          end else begin
            foreach (q[i]) q[i].no_stall = 1'b0;
          end
        end
      end else begin
        checkOutput("in_ready_idle", bus.in_ready, 1'b1);
      end
      if (bus.in_valid && bus.in_ready) begin
`ifdef DADDA_MULT_SIGNED_EN
        s = bus.in_signed;
`else
        s = 1'b0;
`endif
        e.p        = ref_mult(bus.in_a, bus.in_b, s);
        e.tag      = bus.in_tag;
        e.acc      = cyc;
        e.no_stall = 1'b1;
        q.push_back(e);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    bit sg;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
`ifdef DADDA_MULT_SIGNED_EN
    bus.in_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_out_p", bus.out_p, '0);
    checkOutput("rst_out_tag", bus.out_tag, '0);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] single operation latency");
    applyStimulus(16'h7fff, 16'h0002, 4'h5, 1'b0);
    k = 1;
    while (!bus.out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("t1_latency", k, S);
    checkOutput("t1_out_p", bus.out_p, 32'h0000fffe);
    checkOutput("t1_out_tag", bus.out_tag, 4'h5);
    drain();

    $display("[TB] reset mid-flight");
    applyStimulus(16'h1234, 16'h5678, 4'h9, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
    checkOutput("midrst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] back-to-back stream");
    applyStimulus(16'hffff, 16'hffff, 4'h1, 1'b0);
    applyStimulus(16'h00ff, 16'h00ff, 4'h2, 1'b0);
    applyStimulus(16'h0170, 16'h0180, 4'h3, 1'b0);
    drain();

    $display("[TB] output stall");
    bus.out_ready = 1'b0;
    fork
      begin
        applyStimulus(16'h00ff, 16'h00aa, 4'h1, 1'b0);
        applyStimulus(16'h0011, 16'h0022, 4'h2, 1'b0);
        applyStimulus(16'h0033, 16'h0044, 4'h3, 1'b0);
        applyStimulus(16'h0055, 16'h0066, 4'h4, 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        checkOutput("stall_out_valid", bus.out_valid, 1'b1);
        checkOutput("stall_out_p", bus.out_p, 32'h0000a956);
        checkOutput("stall_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] bubbles between operations");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(W'($urandom), W'($urandom), TG'(i + 8), 1'b0);
      @(posedge clk);
      #1;
    end
    drain();

`ifdef DADDA_MULT_SIGNED_EN
    $display("[TB] signed and unsigned interleaved");
    applyStimulus(16'habcd, 16'hff00, 4'h6, 1'b0);
    applyStimulus(16'habcd, 16'hff00, 4'h7, 1'b1);
    applyStimulus(16'hffff, 16'hffff, 4'h8, 1'b1);
    applyStimulus(16'h8000, 16'h8000, 4'h9, 1'b1);
    applyStimulus(16'h8000, 16'h7fff, 4'ha, 1'b1);
    drain();
`endif

    $display("[TB] randomized traffic with random backpressure");
    src_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [W-1:0] a, b;
          a = W'($urandom);
          b = W'($urandom);
          if ($urandom_range(0, 9) == 0) a = '1;
          if ($urandom_range(0, 9) == 0) b = '0;
          if ($urandom_range(0, 9) == 0) b = '1;
          sg = 1'b0;
`ifdef DADDA_MULT_SIGNED_EN
          sg = bit'($urandom_range(0, 1));
`endif
          applyStimulus(a, b, TG'($urandom), sg);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        src_done = 1'b1;
      end
      begin
        while (!src_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/dadda_mult_pipe.md
Name: dadda_mult_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit combinational Dadda multiplier.
- Operand width and pipeline depth are set by parameters.
- Accepts one operand pair per cycle over a valid/ready handshake and returns the full-width product after a fixed latency.
- Carries a user tag alongside each product.
- Sits between the operand source (datapath/ALU issue) and the result sink; backpressure stalls the whole pipe.

Parameters:
- WIDTH, 16, operand width in bits (legal: 4..64).
- PIPE_STAGES, 3, number of register stages from input to output (legal: 1..8); the partial-product reduction layers are distributed across them.
- TAG_W, 4, width of the tag carried with each operation (legal: 1..16).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operand pair present.
- in_ready  output  1  pipe can accept this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_tag  input  TAG_W  user tag, returned with the product.
- out_valid  output  1  product valid.
- out_ready  input  1  sink accepts product.
- out_p  output  2*WIDTH  product.
- out_tag  output  TAG_W  tag of the product on out_p.
- busy  output  1  OR of all stage valid bits.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All stage valid bits, out_valid and busy go to 0; out_p and out_tag go to 0.
  - In-flight operations are discarded, including on reset mid-operation.
  - in_ready is 1 in the first cycle after reset release.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. This is a global stall with no skid buffer.
- Accept: an operand pair is accepted on an edge where in_valid && in_ready. Its product appears with out_valid=1 exactly PIPE_STAGES cycles later, provided no stall occurs.
- Stall: when out_valid=1 and out_ready=0:
  - Every stage holds its contents.
  - out_p and out_tag stay stable.
  - in_ready=0.
  - Inputs presented during a stall are not captured.
- Bubbles: stage valid bits propagate while en=1. A bubble stage does not block acceptance, because en depends only on the last stage.
- Throughput: one result per cycle when in_valid=1 and out_ready=1 are held continuously. No gaps between results.
- Ordering: results and tags leave in acceptance order.
- Arithmetic:
  - out_p = in_a * in_b, full 2*WIDTH bits, no truncation or overflow.
  - Partial products are reduced with a Dadda tree, followed by a final carry-propagate adder in the last stage.
  - Reduction-layer placement across stages is an implementation choice, but latency is exactly PIPE_STAGES.
- PIPE_STAGES=1: the whole tree is combinational and registered once at the output.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: the oldest result drains and the new operand is accepted on the same edge.
- busy=1 whenever any stage holds a valid operation.

Optional Feature:
- Macro: DADDA_MULT_SIGNED_EN.
- When defined, an extra port is added: in_signed input 1.
  - in_signed is sampled with the operands and carried down the pipe.
  - in_signed=1 treats in_a and in_b as two's complement, using Baugh-Wooley partial products, and out_p is the signed 2*WIDTH product.
  - in_signed=0 gives an unsigned product.
  - Signed and unsigned operations may be freely interleaved back to back.
- When not defined: no in_signed port, and all operations are unsigned.

Test Plan:
- Reset, then in_a=16'h7fff, in_b=16'h0002 -> out_valid rises exactly 3 cycles after accept, with out_p=32'h0000fffe and out_tag equal to the issued tag. Asserting rst_n=0 mid-flight -> out_valid and busy are 0 on the next edge.
- Back-to-back stream ffff*ffff, 00ff*00ff, 0170*0180, out_ready=1 -> consecutive results 32'hfffe0001, 32'h0000fe01, 32'h00022800 in order, with no gap cycles.
- 00ff*00aa accepted, then out_ready held 0 for 5 cycles -> out_p=32'h0000a956 held stable and in_ready=0 throughout. Releasing out_ready -> pipe resumes, and no pending or presented operands are lost or duplicated.
- 1-cycle in_valid bubbles interleaved with operations -> each result arrives exactly 3 cycles after its accept, with correct tags.
- With DADDA_MULT_SIGNED_EN defined, abcd*ff00:
  - in_signed=0 -> 32'hab213300.
  - in_signed=1 -> 32'h00543300.
  - ffff*ffff signed -> 32'h00000001.
- Parameter sweep WIDTH=8/PIPE_STAGES=1 and WIDTH=32/PIPE_STAGES=5 -> products match a reference multiply over 10k random pairs, with latency equal to PIPE_STAGES.
